// File: rtl/cpu_branch_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit counter encoding,
// table entry layout and index/tag width helpers.
package cpu_branch_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // Tag is held zero-extended to 32 bits so the struct needs no parameter.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    ctr_t        ctr;
  } entry_t;

  function automatic int unsigned idx_bits(input int unsigned entries);
    return $clog2(entries);
  endfunction

  function automatic logic [31:0] pc_tag(input logic [31:0] pc,
                                         input int unsigned iw,
                                         input int unsigned tb);
    logic [63:0] w_mask;
    w_mask = (64'd1 << tb) - 64'd1;
    return 32'((64'(pc) >> (iw + 2)) & w_mask);
  endfunction

endpackage

// File: rtl/cpu_sat_counter2.sv
// Combinational next-state for a 2-bit saturating direction counter.
module cpu_sat_counter2
  import cpu_branch_pkg::*;
(
  input  ctr_t i_state,
  input  logic i_taken,
  output ctr_t o_next
);

  always_comb begin
    o_next = i_state;
    if (i_taken) begin
      if (i_state != CTR_ST) o_next = i_state + 2'd1;
    end else begin
      if (i_state != CTR_SNT) o_next = i_state - 2'd1;
    end
  end

endmodule

// File: rtl/cpu_branch_predictor.sv
// Dynamic branch predictor with registered lookup and misprediction detection.
// Optional gshare indexing is enabled by defining CPU_BRANCH_GSHARE_EN.
module cpu_branch_predictor
  import cpu_branch_pkg::*;
#(
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        predict_valid,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  input  logic        resolve_pred_taken,
  input  logic [31:0] resolve_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
);

  localparam int unsigned IW = idx_bits(ENTRIES);

  entry_t      r_tab [ENTRIES];
  logic [IW-1:0] w_fidx;
  logic [IW-1:0] w_ridx;
  entry_t      w_fent;
  entry_t      w_rent;
  logic        w_fhit;
  logic        w_rhit;
  logic        w_fpt;
  ctr_t        w_ctr_next;
  logic [31:0] w_correct_pc;

`ifdef CPU_BRANCH_GSHARE_EN
  logic [IW-1:0] r_hist;

  assign w_fidx = fetch_pc[IW+1:2] ^ r_hist;
  assign w_ridx = resolve_pc[IW+1:2] ^ r_hist;

  // Update index above uses the history before this resolve's shift.
  always_ff @(posedge clk) begin
    if (rst)                r_hist <= '0;
    else if (resolve_valid) r_hist <= {r_hist[IW-2:0], resolve_taken};
  end
`else
  assign w_fidx = fetch_pc[IW+1:2];
  assign w_ridx = resolve_pc[IW+1:2];
`endif

  assign w_fent = r_tab[w_fidx];
  assign w_rent = r_tab[w_ridx];
  assign w_fhit = w_fent.valid && (w_fent.tag == pc_tag(fetch_pc, IW, TAG_BITS));
  assign w_rhit = w_rent.valid && (w_rent.tag == pc_tag(resolve_pc, IW, TAG_BITS));
  assign w_fpt  = w_fhit & w_fent.ctr[1];
  assign w_correct_pc = resolve_taken ? resolve_target : resolve_pc + 32'd4;

  cpu_sat_counter2 u_ctr (
    .i_state (w_rent.ctr),
    .i_taken (resolve_taken),
    .o_next  (w_ctr_next)
  );

  // Lookup reads the table through w_fent, so it sees the pre-update entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      predict_valid  <= 1'b0;
      predict_taken  <= 1'b0;
      predict_target <= '0;
    end else begin
      predict_valid <= fetch_valid;
      if (fetch_valid) begin
        predict_taken  <= w_fpt;
        predict_target <= w_fpt ? w_fent.target : fetch_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_tab[i] <= '{1'b0, 32'd0, 32'd0, CTR_WNT};
      end
    end else if (resolve_valid) begin
      if (w_rhit) begin
        r_tab[w_ridx].ctr <= w_ctr_next;
        if (resolve_taken) r_tab[w_ridx].target <= resolve_target;
      end else if (resolve_taken) begin
        r_tab[w_ridx] <= '{1'b1, pc_tag(resolve_pc, IW, TAG_BITS), resolve_target, CTR_WT};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict <= resolve_valid &
                    ((resolve_taken != resolve_pred_taken) ||
                     (w_correct_pc != resolve_pred_target));
      if (resolve_valid) redirect_pc <= w_correct_pc;
    end
  end

endmodule

// File: tb/tb_cpu_branch_predictor.sv
// Table-driven self-checking bench for cpu_branch_predictor with a scoreboard queue.
module tb_cpu_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        predict_valid;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        resolve_pred_taken;
  logic [31:0] resolve_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;

  cpu_branch_predictor #(.ENTRIES(64), .TAG_BITS(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .fetch_valid         (fetch_valid),
    .fetch_pc            (fetch_pc),
    .predict_valid       (predict_valid),
    .predict_taken       (predict_taken),
    .predict_target      (predict_target),
    .resolve_valid       (resolve_valid),
    .resolve_pc          (resolve_pc),
    .resolve_taken       (resolve_taken),
    .resolve_target      (resolve_target),
    .resolve_pred_taken  (resolve_pred_taken),
    .resolve_pred_target (resolve_pred_target),
    .mispredict          (mispredict),
    .redirect_pc         (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fv;
    logic [31:0] fpc;
    logic        rv;
    logic [31:0] rpc;
    logic        rt;
    logic [31:0] rtgt;
    logic        rpt;
    logic [31:0] rptgt;
    logic        epv;
    logic        ept;
    logic [31:0] eptgt;
    logic        emp;
    logic [31:0] erpc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic add(input logic r, input logic fv, input logic [31:0] fpc,
                     input logic rv, input logic [31:0] rpc, input logic rt,
                     input logic [31:0] rtgt, input logic rpt, input logic [31:0] rptgt,
                     input logic epv, input logic ept, input logic [31:0] eptgt,
                     input logic emp, input logic [31:0] erpc);
    vec_t v;
    v.rst = r; v.fv = fv; v.fpc = fpc; v.rv = rv; v.rpc = rpc; v.rt = rt;
    v.rtgt = rtgt; v.rpt = rpt; v.rptgt = rptgt; v.epv = epv; v.ept = ept;
    v.eptgt = eptgt; v.emp = emp; v.erpc = erpc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    rst = 1'b0; fetch_valid = 1'b0; fetch_pc = '0; resolve_valid = 1'b0;
    resolve_pc = '0; resolve_taken = 1'b0; resolve_target = '0;
    resolve_pred_taken = 1'b0; resolve_pred_target = '0;

    //  rst fv fpc           rv rpc          rt rtgt          rpt rptgt        epv ept eptgt         emp erpc
    add(1, 0, 32'h0,       0, 32'h0,     0, 32'h0,      0, 32'h0,     0, 0, 32'h0,       0, 32'h0);
    add(0, 0, 32'h0,       1, 32'h108,   1, 32'h1000,   0, 32'h10C,   0, 0, 32'h0,       1, 32'h1000);
    add(0, 0, 32'h0,       1, 32'h104,   1, 32'h2000,   0, 32'h108,   0, 0, 32'h0,       1, 32'h2000);
`ifdef CPU_BRANCH_GSHARE_EN
    add(0, 1, 32'h10C,     0, 32'h0,     0, 32'h0,      0, 32'h0,     1, 1, 32'h2000,    0, 32'h0);
    add(0, 1, 32'h104,     0, 32'h0,     0, 32'h0,      0, 32'h0,     1, 1, 32'h1000,    0, 32'h0);
`else
    add(0, 1, 32'h10C,     0, 32'h0,     0, 32'h0,      0, 32'h0,     1, 0, 32'h110,     0, 32'h0);
    add(0, 1, 32'h104,     0, 32'h0,     0, 32'h0,      0, 32'h0,     1, 1, 32'h2000,    0, 32'h0);
`endif
    add(0, 1, 32'h100,     0, 32'h0,     0, 32'h0,      0, 32'h0,     1, 0, 32'h104,     0, 32'h0);
    // reset arriving with a fetch and a mispredicting resolve in flight
    add(1, 1, 32'h104,     1, 32'h100,   1, 32'h80,     0, 32'h104,   0, 0, 32'h0,       0, 32'h0);
    add(0, 1, 32'h104,     0, 32'h0,     0, 32'h0,      0, 32'h0,     1, 0, 32'h108,     0, 32'h0);
    add(0, 1, 32'h100,     0, 32'h0,     0, 32'h0,      0, 32'h0,     1, 0, 32'h104,     0, 32'h0);
`ifndef CPU_BRANCH_GSHARE_EN
    add(0, 0, 32'h0,       1, 32'h100,   1, 32'h40,     0, 32'h104,   0, 0, 32'h104,     1, 32'h40);
    add(0, 1, 32'h100,     0, 32'h0,     0, 32'h0,      0, 32'h0,     1, 1, 32'h40,      0, 32'h0);
    for (int i = 0; i < 4; i++)
      add(0, 0, 32'h0,     1, 32'h100,   1, 32'h40,     1, 32'h40,    0, 1, 32'h40,      0, 32'h0);
    add(0, 0, 32'h0,       1, 32'h100,   0, 32'h40,     1, 32'h40,    0, 1, 32'h40,      1, 32'h104);
    add(0, 1, 32'h100,     0, 32'h0,     0, 32'h0,      0, 32'h0,     1, 1, 32'h40,      0, 32'h0);
    add(0, 0, 32'h0,       1, 32'h200,   0, 32'h300,    0, 32'h204,   0, 1, 32'h40,      0, 32'h0);
    add(0, 1, 32'h200,     0, 32'h0,     0, 32'h0,      0, 32'h0,     1, 0, 32'h204,     0, 32'h0);
    add(0, 1, 32'h100,     1, 32'h100,   0, 32'h40,     1, 32'h40,    1, 1, 32'h40,      1, 32'h104);
    add(0, 1, 32'h100,     0, 32'h0,     0, 32'h0,      0, 32'h0,     1, 0, 32'h104,     0, 32'h0);
    add(0, 1, 32'hFFFFFFFC,0, 32'h0,     0, 32'h0,      0, 32'h0,     1, 0, 32'h0,       0, 32'h0);
    add(0, 0, 32'h0,       1, 32'h300,   1, 32'h500,    0, 32'h304,   0, 0, 32'h0,       1, 32'h500);
    add(0, 0, 32'h0,       1, 32'h300,   0, 32'h500,    0, 32'h308,   0, 0, 32'h0,       1, 32'h304);
    add(0, 1, 32'h100,     0, 32'h0,     0, 32'h0,      0, 32'h0,     1, 0, 32'h104,     0, 32'h0);
    add(0, 1, 32'h300,     0, 32'h0,     0, 32'h0,      0, 32'h0,     1, 0, 32'h304,     0, 32'h0);
    add(0, 0, 32'h0,       1, 32'h300,   1, 32'h600,    0, 32'h304,   0, 0, 32'h304,     1, 32'h600);
    add(0, 1, 32'h300,     0, 32'h0,     0, 32'h0,      0, 32'h0,     1, 1, 32'h600,     0, 32'h0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t e;
      @(negedge clk);
      rst = vecs[i].rst; fetch_valid = vecs[i].fv; fetch_pc = vecs[i].fpc;
      resolve_valid = vecs[i].rv; resolve_pc = vecs[i].rpc;
      resolve_taken = vecs[i].rt; resolve_target = vecs[i].rtgt;
      resolve_pred_taken = vecs[i].rpt; resolve_pred_target = vecs[i].rptgt;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("predict_valid",  i, {31'd0, predict_valid}, {31'd0, e.epv});
      check("predict_taken",  i, {31'd0, predict_taken}, {31'd0, e.ept});
      check("predict_target", i, predict_target, e.eptgt);
      check("mispredict",     i, {31'd0, mispredict}, {31'd0, e.emp});
      if (e.emp || e.rst) check("redirect_pc", i, redirect_pc, e.erpc);
    end

    @(negedge clk);
    rst = 1'b0; fetch_valid = 1'b0; resolve_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
